// File: rtl/bin_win3x3_gen_if.sv
// Pixel-in / window-out bundle for the 3x3 binary window generator.
// The pixel source is the master; the window generator is the slave.
interface bin_win3x3_gen_if;
   logic frame_sync;
   logic pix_en;
   logic pix_bit;
   logic data_en;
   logic win_last;
   logic p11, p12, p13;
   logic p21, p22, p23;
   logic p31, p32, p33;

   modport master (
      output frame_sync, pix_en, pix_bit,
      input  data_en, win_last,
      input  p11, p12, p13, p21, p22, p23, p31, p32, p33
   );

   modport slave (
      input  frame_sync, pix_en, pix_bit,
      output data_en, win_last,
      output p11, p12, p13, p21, p22, p23, p31, p32, p33
   );
endinterface

// File: rtl/bin_win3x3_gen.sv
// 3x3 binary neighbourhood window generator with two 1-bit line buffers.
// Taps outside the image are replaced by BORDER_VAL, based on row/column position.
module bin_win3x3_gen #(
   parameter int   IMG_W      = 640,
   parameter int   IMG_H      = 480,
   parameter logic BORDER_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   bin_win3x3_gen_if.slave  bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic          lb1 [IMG_W];
   logic          lb2 [IMG_W];
   logic          lb1_rd, lb2_rd;
   logic [2:0]    hist1_q, hist2_q;
   logic [8:0]    win_q, win_d;
   logic          data_en_q, win_last_q;
   logic          row0, row1, col0, col1;

   // frame_sync overrides the stored position so a coincident pixel is (0,0)
   always_comb begin
      cur_col = bus.frame_sync ? '0 : col_q;
      cur_row = bus.frame_sync ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (bus.pix_en) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
      end else if (bus.frame_sync) begin
         col_d = '0;
         row_d = '0;
      end
   end

   assign lb1_rd = lb1[cur_col];
   assign lb2_rd = lb2[cur_col];

   // Read-before-write: LB2 takes the old LB1 entry as LB1 takes the new pixel
   always_ff @(posedge clk) begin
      if (bus.pix_en) begin
         lb1[cur_col] <= bus.pix_bit;
         lb2[cur_col] <= lb1_rd;
      end
   end

   assign row0 = (cur_row == '0);
   assign row1 = (cur_row == RW'(1));
   assign col0 = (cur_col == '0);
   assign col1 = (cur_col == CW'(1));

   // Window bit order is {p11,p12,p13,p21,p22,p23,p31,p32,p33}; history is {top,mid,bot}
   always_comb begin
      win_d    = '0;
      win_d[8] = (row0 | row1 | col0 | col1) ? BORDER_VAL : hist2_q[2];
      win_d[7] = (row0 | row1 | col0)        ? BORDER_VAL : hist1_q[2];
      win_d[6] = (row0 | row1)               ? BORDER_VAL : lb2_rd;
      win_d[5] = (row0 | col0 | col1)        ? BORDER_VAL : hist2_q[1];
      win_d[4] = (row0 | col0)               ? BORDER_VAL : hist1_q[1];
      win_d[3] = row0                        ? BORDER_VAL : lb1_rd;
      win_d[2] = (col0 | col1)               ? BORDER_VAL : hist2_q[0];
      win_d[1] = col0                        ? BORDER_VAL : hist1_q[0];
      win_d[0] = bus.pix_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         row_q      <= '0;
         hist1_q    <= '0;
         hist2_q    <= '0;
         win_q      <= '0;
         data_en_q  <= 1'b0;
         win_last_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         data_en_q  <= bus.pix_en;
         win_last_q <= bus.pix_en && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
         if (bus.pix_en) begin
            hist2_q <= hist1_q;
            hist1_q <= {lb2_rd, lb1_rd, bus.pix_bit};
            win_q   <= win_d;
         end
      end
   end

   assign bus.data_en  = data_en_q;
   assign bus.win_last = win_last_q;
   assign {bus.p11, bus.p12, bus.p13,
           bus.p21, bus.p22, bus.p23,
           bus.p31, bus.p32, bus.p33} = win_q;
endmodule

// File: tb/tb_bin_win3x3_gen.sv
// Directed bench for bin_win3x3_gen on an 8x4 image; expected windows come
// from a whole-image reference plus hand-computed spot values.
module tb_bin_win3x3_gen;
   localparam int W = 8;
   localparam int H = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bin_win3x3_gen_if bus();

   bin_win3x3_gen #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(1'b1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [8:0] taps;
   assign taps = {bus.p11, bus.p12, bus.p13, bus.p21, bus.p22, bus.p23, bus.p31, bus.p32, bus.p33};

   int total = 0;
   int bad = 0;
   int r_pos = 0;
   int c_pos = 0;
   int nwin = 0;
   logic [8:0] last_exp = '0;
   logic img [H][W];

   task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic fs, input logic en, input logic b);
      @(negedge clk);
      bus.frame_sync = fs;
      bus.pix_en     = en;
      bus.pix_bit    = b;
      @(posedge clk);
      #1;
   endtask

   // Reference window taken straight from the image, 1 where a tap leaves the image
   function automatic logic [8:0] refWin(input int r, input int c);
      logic [8:0] w;
      int rr, cc;
      w = '0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            rr = r - 2 + dr;
            cc = c - 2 + dc;
            w[8 - (dr * 3 + dc)] = (rr < 0 || cc < 0) ? 1'b1 : img[rr][cc];
         end
      end
      return w;
   endfunction

   task automatic sendPixel(input logic fs, input logic b);
      if (fs) begin
         r_pos = 0;
         c_pos = 0;
      end
      img[r_pos][c_pos] = b;
      applyStimulus(fs, 1'b1, b);
      last_exp = refWin(r_pos, c_pos);
      if (bus.data_en) nwin++;
      checkOutput($sformatf("data_en(%0d,%0d)", r_pos, c_pos), 9'(bus.data_en), 9'd1);
      checkOutput($sformatf("win_last(%0d,%0d)", r_pos, c_pos), 9'(bus.win_last),
                  9'((r_pos == H - 1) && (c_pos == W - 1)));
      checkOutput($sformatf("taps(%0d,%0d)", r_pos, c_pos), taps, last_exp);
   endtask

   task automatic advancePos();
      if (c_pos == W - 1) begin
         c_pos = 0;
         r_pos = (r_pos == H - 1) ? 0 : r_pos + 1;
      end else begin
         c_pos++;
      end
   endtask

   task automatic sendGap();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("gap_data_en", 9'(bus.data_en), 9'd0);
      checkOutput("gap_win_last", 9'(bus.win_last), 9'd0);
      checkOutput("gap_hold", taps, last_exp);
   endtask

   function automatic logic col3Pix(input int c);
      return (c == 3) ? 1'b0 : 1'b1;
   endfunction

   initial begin
      bus.frame_sync = 1'b0;
      bus.pix_en     = 1'b0;
      bus.pix_bit    = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_data_en", 9'(bus.data_en), 9'd0);
      checkOutput("reset_win_last", 9'(bus.win_last), 9'd0);
      checkOutput("reset_taps", taps, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;

      // All-1 frame, continuous
      $display("[TB] all-ones frame");
      nwin = 0;
      for (int i = 0; i < W * H; i++) begin
         sendPixel(1'b0, 1'b1);
         checkOutput("ones_taps", taps, 9'h1FF);
         advancePos();
      end
      checkOutput("ones_window_count", 9'(nwin), 9'd32);
      sendGap();

      // Column 3 black, continuous
      $display("[TB] column-3 frame");
      for (int i = 0; i < W * H; i++) begin
         sendPixel(i == 0, col3Pix(c_pos));
         if (r_pos == 2 && c_pos == 5) checkOutput("col3_hand(2,5)", taps, 9'h0DB);
         if (r_pos == 2 && c_pos == 3) checkOutput("col3_hand(2,3)", taps, 9'h1B6);
         advancePos();
      end

      // Single foreground pixel at (1,1)
      $display("[TB] single-dot frame");
      for (int i = 0; i < W * H; i++) begin
         sendPixel(i == 0, !(r_pos == 1 && c_pos == 1));
         if (r_pos == 1 && c_pos == 1) checkOutput("dot_hand(1,1)", taps, 9'h1FE);
         if (r_pos == 2 && c_pos == 2) checkOutput("dot_hand(2,2)", taps, 9'h1EF);
         if (r_pos == 3 && c_pos == 3) checkOutput("dot_hand(3,3)", taps, 9'h0FF);
         advancePos();
      end

      // Column 3 pattern again with random blanking gaps
      $display("[TB] column-3 frame with gaps");
      for (int i = 0; i < W * H; i++) begin
         while ($urandom_range(0, 1) == 0) sendGap();
         sendPixel(i == 0, col3Pix(c_pos));
         if (r_pos == 2 && c_pos == 5) checkOutput("gap_hand(2,5)", taps, 9'h0DB);
         advancePos();
      end
      sendGap();

      // Abort mid-frame at (2,5) with frame_sync, then an all-0 frame
      $display("[TB] frame_sync abort");
      for (int i = 0; i < 2 * W + 5; i++) begin
         sendPixel(i == 0, col3Pix(c_pos));
         advancePos();
      end
      for (int i = 0; i < W * H; i++) begin
         sendPixel(i == 0, 1'b0);
         if (i == 0) checkOutput("sync_first", taps, 9'h1FE);
         if (r_pos == 1 && c_pos == 4) checkOutput("sync_hand(1,4)", taps, 9'h1C0);
         advancePos();
      end

      // Reset mid-frame at (3,2), then restart without frame_sync
      $display("[TB] reset mid-frame");
      for (int i = 0; i < 3 * W + 2; i++) begin
         sendPixel(i == 0, col3Pix(c_pos));
         advancePos();
      end
      @(negedge clk);
      rst_n = 1'b0;
      bus.pix_en = 1'b0;
      bus.frame_sync = 1'b0;
      #1;
      checkOutput("rst_async_data_en", 9'(bus.data_en), 9'd0);
      checkOutput("rst_async_taps", taps, 9'h000);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_hold_data_en", 9'(bus.data_en), 9'd0);
      checkOutput("rst_hold_win_last", 9'(bus.win_last), 9'd0);
      checkOutput("rst_hold_taps", taps, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;
      last_exp = '0;
      r_pos = 0;
      c_pos = 0;
      sendGap();
      for (int i = 0; i < W * H; i++) begin
         sendPixel(1'b0, (i == 0) ? 1'b0 : col3Pix(c_pos));
         if (i == 0) checkOutput("rst_first", taps, 9'h1FE);
         advancePos();
      end
      sendGap();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
